// File: rtl/countdown_timer_4_bit_if.sv
// Control and status bundle for the loadable countdown timer.
// master drives the controls; slave is the timer itself.
interface countdown_timer_4_bit_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             stop;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, pause, stop,
    input  out, busy, done
  );

  modport slave (
    input  load, load_val, start, pause, stop,
    output out, busy, done
  );
endinterface

// File: rtl/countdown_timer_4_bit.sv
// Loadable down-counting timer with start/pause/stop control and a one-cycle done pulse.
// Optional periodic mode: define COUNTDOWN_AUTORELOAD_EN to reload from reload_reg at terminal count.
module countdown_timer_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic                     clk_out,
  input  logic                     rst,
  countdown_timer_4_bit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Every control input is resolved in the order stop > load > start/pause > decrement.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load) begin
          out_d    = bus.load_val;
          reload_d = bus.load_val;
        end else if (bus.start) begin
          if (out_q != '0) begin
            state_d = RUN;
          end else begin
            done_d = 1'b1;  // zero-length timer expires immediately
          end
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load) begin
          out_d    = bus.load_val;
          reload_d = bus.load_val;
        end else if (bus.pause) begin
          state_d = PAUSED;
        end else if (out_q > WIDTH'(1)) begin
          out_d = out_q - WIDTH'(1);
        end else if (out_q == WIDTH'(1)) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          done_d = 1'b1;
          if (reload_q != '0) begin
            out_d = reload_q;
          end else begin
            out_d   = '0;
            state_d = IDLE;
          end
`else
          out_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          out_d   = '0;
          state_d = IDLE;
        end
      end

      PAUSED: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load) begin
          out_d    = bus.load_val;
          reload_d = bus.load_val;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        out_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_countdown_timer_4_bit.sv
// Directed scoreboard bench for countdown_timer_4_bit; expectations follow COUNTDOWN_AUTORELOAD_EN.
module tb_countdown_timer_4_bit;

`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk_out;
  logic rst;

  countdown_timer_4_bit_if #(.WIDTH(4)) bus ();

  countdown_timer_4_bit #(.WIDTH(4)) dut (
    .clk_out (clk_out),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] out;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_out"},  32'(bus.out),  32'(e.out));
      check({e.tag, "_busy"}, 32'(bus.busy), 32'(e.busy));
      check({e.tag, "_done"}, 32'(bus.done), 32'(e.done));
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge result, then compare after the edge.
  task automatic step(input string tag,
                      input logic ld, input logic [3:0] lv,
                      input logic st, input logic pa, input logic sp,
                      input logic [3:0] eo, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk_out);
    bus.load     = ld;
    bus.load_val = lv;
    bus.start    = st;
    bus.pause    = pa;
    bus.stop     = sp;
    e.out  = eo;
    e.busy = eb;
    e.done = ed;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk_out);
    #1;
    sample();
  endtask

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.stop     = 1'b0;
    #12;
    check("reset_out",  32'(bus.out),  32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    @(negedge clk_out);
    rst = 1'b0;

    // Zero-length timer: start with out==0 pulses done for one cycle, never busy.
    step("t1_start0", 0, 4'd0, 1, 0, 0, 4'd0, 0, 1);
    step("t1_after",  0, 4'd0, 0, 0, 0, 4'd0, 0, 0);

    // Load 5 and count to terminal.
    step("t2_load",  1, 4'd5, 0, 0, 0, 4'd5, 0, 0);
    step("t2_start", 0, 4'd0, 1, 0, 0, 4'd5, 1, 0);
    step("t2_c4",    0, 4'd0, 0, 0, 0, 4'd4, 1, 0);
    step("t2_c3",    0, 4'd0, 0, 0, 0, 4'd3, 1, 0);
    step("t2_c2",    0, 4'd0, 0, 0, 0, 4'd2, 1, 0);
    step("t2_c1",    0, 4'd0, 0, 0, 0, 4'd1, 1, 0);
    step("t2_term",  0, 4'd0, 0, 0, 0, AUTO ? 4'd5 : 4'd0, AUTO, 1);
    step("t2_stop",  0, 4'd0, 0, 0, 1, AUTO ? 4'd5 : 4'd0, 0, 0);

    // Pause holds the count; release takes one edge before decrementing resumes.
    step("t3_load",   1, 4'd6, 0, 0, 0, 4'd6, 0, 0);
    step("t3_start",  0, 4'd0, 1, 0, 0, 4'd6, 1, 0);
    step("t3_c5",     0, 4'd0, 0, 0, 0, 4'd5, 1, 0);
    step("t3_c4",     0, 4'd0, 0, 0, 0, 4'd4, 1, 0);
    step("t3_p1",     0, 4'd0, 0, 1, 0, 4'd4, 1, 0);
    step("t3_p2",     0, 4'd0, 1, 1, 0, 4'd4, 1, 0);
    step("t3_p3",     0, 4'd0, 0, 1, 0, 4'd4, 1, 0);
    step("t3_resume", 0, 4'd0, 0, 0, 0, 4'd4, 1, 0);
    step("t3_c3",     0, 4'd0, 0, 0, 0, 4'd3, 1, 0);
    step("t3_stop",   0, 4'd0, 0, 0, 1, 4'd3, 0, 0);

    // Stop beats a simultaneous load; load while running restarts the count.
    step("t4_load",     1, 4'd5, 0, 0, 0, 4'd5, 0, 0);
    step("t4_start",    0, 4'd0, 1, 0, 0, 4'd5, 1, 0);
    step("t4_c4",       0, 4'd0, 0, 0, 0, 4'd4, 1, 0);
    step("t4_c3",       0, 4'd0, 0, 0, 0, 4'd3, 1, 0);
    step("t4_stopload", 1, 4'd7, 0, 0, 1, 4'd3, 0, 0);
    step("t4_restart",  0, 4'd0, 1, 0, 0, 4'd3, 1, 0);
    step("t4_load9",    1, 4'd9, 0, 0, 0, 4'd9, 1, 0);
    step("t4_c8",       0, 4'd0, 0, 0, 0, 4'd8, 1, 0);
    step("t4_c7",       0, 4'd0, 0, 0, 0, 4'd7, 1, 0);
    step("t4_stop",     0, 4'd0, 0, 0, 1, 4'd7, 0, 0);

    // Asynchronous reset mid-count takes effect without a clock edge.
    step("t5_load",  1, 4'd4, 0, 0, 0, 4'd4, 0, 0);
    step("t5_start", 0, 4'd0, 1, 0, 0, 4'd4, 1, 0);
    step("t5_c3",    0, 4'd0, 0, 0, 0, 4'd3, 1, 0);
    step("t5_c2",    0, 4'd0, 0, 0, 0, 4'd2, 1, 0);
    @(negedge clk_out);
    bus.start = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_rst_out",  32'(bus.out),  32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk_out);
    rst = 1'b0;
    step("t5_after", 0, 4'd0, 0, 0, 0, 4'd0, 0, 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    // Periodic mode: done every 3 cycles with out cycling 3,2,1.
    step("t6_load",  1, 4'd3, 0, 0, 0, 4'd3, 0, 0);
    step("t6_start", 0, 4'd0, 1, 0, 0, 4'd3, 1, 0);
    step("t6_c2a",   0, 4'd0, 0, 0, 0, 4'd2, 1, 0);
    step("t6_c1a",   0, 4'd0, 0, 0, 0, 4'd1, 1, 0);
    step("t6_rl1",   0, 4'd0, 0, 0, 0, 4'd3, 1, 1);
    step("t6_c2b",   0, 4'd0, 0, 0, 0, 4'd2, 1, 0);
    step("t6_c1b",   0, 4'd0, 0, 0, 0, 4'd1, 1, 0);
    step("t6_rl2",   0, 4'd0, 0, 0, 0, 4'd3, 1, 1);
    step("t6_stop",  0, 4'd0, 0, 0, 1, 4'd3, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
